// File: rtl/pipe_skid_stage.sv
// Pipeline stage register with valid/ready handshake, optional skid entry,
// flush, bubble control gating and a saturating back-pressure counter.
module pipe_skid_stage #(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned CTRL_W    = 8,
  parameter int unsigned SKID      = 1,
  parameter int unsigned ZERO_DATA = 1,
  parameter int unsigned CNT_W     = 16
) (
  input  logic              clk,
  input  logic              CLR,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cnt
);

  // Main entry (drives outputs) and skid entry
  logic              m_valid_q, m_valid_d;
  logic [DATA_W-1:0] m_data_q,  m_data_d;
  logic [CTRL_W-1:0] m_ctrl_q,  m_ctrl_d;
  logic              s_valid_q, s_valid_d;
  logic [DATA_W-1:0] s_data_q,  s_data_d;
  logic [CTRL_W-1:0] s_ctrl_q,  s_ctrl_d;
  logic [CNT_W-1:0]  cnt_q,     cnt_d;
  logic              in_fire;
  logic              out_fire;

  // With a skid entry in_ready is purely state; without it, a consuming
  // downstream frees the single entry in the same cycle.
  assign in_ready = (SKID != 0) ? ~s_valid_q : (~m_valid_q | out_ready);

  // Handshake bookkeeping and next-state selection for both entries
  always_comb begin
    m_valid_d = m_valid_q;
    m_data_d  = m_data_q;
    m_ctrl_d  = m_ctrl_q;
    s_valid_d = s_valid_q;
    s_data_d  = s_data_q;
    s_ctrl_d  = s_ctrl_q;
    cnt_d     = cnt_q;
    in_fire   = in_valid & in_ready;
    out_fire  = m_valid_q & out_ready;

    if (m_valid_q && !out_ready && !(&cnt_q)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    if (SKID != 0) begin
      if (!m_valid_q) begin
        if (in_fire) begin
          m_valid_d = 1'b1;
          m_data_d  = in_data;
          m_ctrl_d  = in_ctrl;
        end
      end else if (out_fire) begin
        if (s_valid_q) begin
          m_valid_d = 1'b1;
          m_data_d  = s_data_q;
          m_ctrl_d  = s_ctrl_q;
          s_valid_d = 1'b0;
        end else if (in_fire) begin
          m_valid_d = 1'b1;
          m_data_d  = in_data;
          m_ctrl_d  = in_ctrl;
        end else begin
          m_valid_d = 1'b0;
        end
      end else if (in_fire) begin
        s_valid_d = 1'b1;
        s_data_d  = in_data;
        s_ctrl_d  = in_ctrl;
      end
    end else begin
      if (in_fire) begin
        m_valid_d = 1'b1;
        m_data_d  = in_data;
        m_ctrl_d  = in_ctrl;
      end else if (out_fire) begin
        m_valid_d = 1'b0;
      end
    end
  end

  // State update: CLR beats flush beats handshakes; flush keeps the counter
  always_ff @(posedge clk) begin
    if (CLR || flush) begin
      m_valid_q <= 1'b0;
      s_valid_q <= 1'b0;
      m_ctrl_q  <= '0;
      s_ctrl_q  <= '0;
      if (ZERO_DATA != 0) begin
        m_data_q <= '0;
        s_data_q <= '0;
      end
      if (CLR) begin
        cnt_q <= '0;
      end
    end else begin
      m_valid_q <= m_valid_d;
      m_data_q  <= m_data_d;
      m_ctrl_q  <= m_ctrl_d;
      s_valid_q <= s_valid_d;
      s_data_q  <= s_data_d;
      s_ctrl_q  <= s_ctrl_d;
      cnt_q     <= cnt_d;
    end
  end

  assign out_valid = m_valid_q;
  assign out_data  = m_data_q;
  assign out_ctrl  = m_ctrl_q & {CTRL_W{m_valid_q}};
  assign occupancy = {1'b0, m_valid_q} + {1'b0, s_valid_q};
  assign stall_cnt = cnt_q;

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Bench for pipe_skid_stage: a SKID=1/ZERO_DATA=1 instance (u0) and a
// SKID=0/ZERO_DATA=0 instance (u1) share stimulus; each is tracked by a
// FIFO-level model and pinned by hand-computed literal expectations.
module tb_pipe_skid_stage;

  localparam int unsigned DW   = 32;
  localparam int unsigned CW   = 8;
  localparam int unsigned NW   = 4;
  localparam int          CMAX = 15;

  logic          clk = 1'b0;
  logic          CLR = 1'b1;
  logic          flush = 1'b0;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic [CW-1:0] in_ctrl = '0;
  logic          out_ready = 1'b0;

  logic          ir  [2];
  logic          ov  [2];
  logic [DW-1:0] od  [2];
  logic [CW-1:0] oc  [2];
  logic [1:0]    occ [2];
  logic [NW-1:0] sc  [2];

  int pass_cnt = 0;
  int total_cnt = 0;

  pipe_skid_stage #(.DATA_W(DW), .CTRL_W(CW), .SKID(1), .ZERO_DATA(1), .CNT_W(NW)) u0 (
    .clk(clk), .CLR(CLR), .flush(flush), .in_valid(in_valid), .in_ready(ir[0]),
    .in_data(in_data), .in_ctrl(in_ctrl), .out_valid(ov[0]), .out_ready(out_ready),
    .out_data(od[0]), .out_ctrl(oc[0]), .occupancy(occ[0]), .stall_cnt(sc[0]));

  pipe_skid_stage #(.DATA_W(DW), .CTRL_W(CW), .SKID(0), .ZERO_DATA(0), .CNT_W(NW)) u1 (
    .clk(clk), .CLR(CLR), .flush(flush), .in_valid(in_valid), .in_ready(ir[1]),
    .in_data(in_data), .in_ctrl(in_ctrl), .out_valid(ov[1]), .out_ready(out_ready),
    .out_data(od[1]), .out_ctrl(oc[1]), .occupancy(occ[1]), .stall_cnt(sc[1]));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
  endtask

  // Model: each instance is a FIFO of capacity 2 (skid) or 1 (no skid)
  logic [DW-1:0] bd [2][2];
  logic [CW-1:0] bc [2][2];
  int  mn   [2] = '{0, 0};
  int  mcnt [2] = '{0, 0};
  bit  mdz  [2] = '{0, 0};
  bit  started = 0;

  function automatic bit model_ready(input int k);
    if (k == 0) return mn[0] < 2;
    return (mn[1] == 0) || out_ready;
  endfunction

  // Model update on every rising edge
  initial begin
    bit rdy, of, inf;
    forever begin
      @(posedge clk);
      for (int k = 0; k < 2; k++) begin
        rdy = model_ready(k);
        if (CLR) begin
          mn[k] = 0; mcnt[k] = 0; mdz[k] = (k == 0); started = 1;
        end else if (flush) begin
          mn[k] = 0; if (k == 0) mdz[k] = 1;
        end else begin
          of  = (mn[k] > 0) && out_ready;
          inf = in_valid && rdy;
          if (mn[k] > 0 && !out_ready && mcnt[k] < CMAX) mcnt[k]++;
          if (of) begin
            bd[k][0] = bd[k][1]; bc[k][0] = bc[k][1]; mn[k]--;
          end
          if (inf) begin
            bd[k][mn[k]] = in_data; bc[k][mn[k]] = in_ctrl; mn[k]++; mdz[k] = 0;
          end
        end
      end
    end
  end

  // Compare every DUT output against the model on each falling edge
  initial begin
    forever begin
      @(negedge clk);
      if (started) begin
        for (int k = 0; k < 2; k++) begin
          chk($sformatf("u%0d.out_valid", k), 32'(ov[k]), 32'(mn[k] > 0));
          chk($sformatf("u%0d.in_ready", k), 32'(ir[k]), 32'(model_ready(k)));
          chk($sformatf("u%0d.occupancy", k), 32'(occ[k]), 32'(mn[k]));
          chk($sformatf("u%0d.stall_cnt", k), 32'(sc[k]), 32'(mcnt[k]));
          chk($sformatf("u%0d.out_ctrl", k), 32'(oc[k]), (mn[k] > 0) ? 32'(bc[k][0]) : 32'd0);
          if (mn[k] > 0) chk($sformatf("u%0d.out_data", k), od[k], bd[k][0]);
          else if (mdz[k]) chk($sformatf("u%0d.out_data_zero", k), od[k], 32'd0);
        end
      end
    end
  end

  // Apply one input vector for one clock; returns at the following negedge
  task automatic apply(input bit v, input logic [DW-1:0] d, input logic [CW-1:0] c,
                       input bit ordy, input bit fl, input bit clr);
    #1;
    in_valid = v; in_data = d; in_ctrl = c; out_ready = ordy; flush = fl; CLR = clr;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    @(negedge clk);
    apply(0, '0, '0, 0, 0, 1);
    apply(0, '0, '0, 0, 0, 0);
    chk("reset out_valid", 32'(ov[0]), 32'd0);
    chk("reset out_data", od[0], 32'd0);
    chk("reset occupancy", 32'(occ[0]), 32'd0);
    chk("reset stall_cnt", 32'(sc[0]), 32'd0);
    chk("reset in_ready skid", 32'(ir[0]), 32'd1);
    chk("reset in_ready noskid", 32'(ir[1]), 32'd1);

    // Streaming at full rate
    for (int i = 0; i < 8; i++) begin
      apply(1, 32'h100 + 32'(i), 8'h5A, 1, 0, 0);
      chk($sformatf("stream data %0d", i), od[0], 32'h100 + 32'(i));
      chk($sformatf("stream occ %0d", i), 32'(occ[0]), 32'd1);
      chk($sformatf("stream noskid data %0d", i), od[1], 32'h100 + 32'(i));
    end
    apply(0, '0, '0, 1, 0, 0);
    chk("stream stall_cnt", 32'(sc[0]), 32'd0);

    // Back-pressure fills the skid entry
    apply(1, 32'hA, 8'h01, 0, 0, 0);
    apply(1, 32'hB, 8'h02, 0, 0, 0);
    chk("bp occ full", 32'(occ[0]), 32'd2);
    chk("bp in_ready low", 32'(ir[0]), 32'd0);
    chk("bp head A", od[0], 32'hA);
    apply(1, 32'hC, 8'h03, 0, 0, 0);
    apply(1, 32'hC, 8'h03, 0, 0, 0);
    chk("bp stall_cnt", 32'(sc[0]), 32'd3);
    apply(1, 32'hC, 8'h03, 1, 0, 0);
    chk("bp head B", od[0], 32'hB);
    chk("bp in_ready back", 32'(ir[0]), 32'd1);
    apply(1, 32'hC, 8'h03, 1, 0, 0);
    chk("bp head C", od[0], 32'hC);
    apply(0, '0, '0, 1, 0, 0);
    chk("bp drained", 32'(ov[0]), 32'd0);

    // Flush while both entries are held
    apply(1, 32'h11, 8'hFF, 0, 0, 0);
    apply(1, 32'h22, 8'hFF, 0, 0, 0);
    chk("fl occ before", 32'(occ[0]), 32'd2);
    chk("fl ctrl before", 32'(oc[0]), 32'hFF);
    apply(1, 32'h33, 8'hFF, 0, 1, 0);
    chk("fl out_valid", 32'(ov[0]), 32'd0);
    chk("fl out_ctrl", 32'(oc[0]), 32'd0);
    chk("fl occ", 32'(occ[0]), 32'd0);
    chk("fl out_data zeroed", od[0], 32'd0);
    chk("fl stall kept", 32'(sc[0]), 32'd4);
    chk("fl noskid data retained", od[1], 32'h11);
    apply(0, '0, '0, 1, 0, 0);
    chk("fl input discarded", 32'(ov[0]), 32'd0);

    // Bubbles never show control bits
    for (int i = 0; i < 4; i++) begin
      apply(1, 32'h200 + 32'(i), 8'h81, 1, 0, 0);
      chk("bubble ctrl valid", 32'(oc[0]), 32'h81);
      apply(0, '0, 8'h81, 1, 0, 0);
      chk("bubble ctrl gated", 32'(oc[0]), 32'd0);
    end

    // Single-entry combinational pass-through
    apply(1, 32'h300, 8'h0F, 0, 0, 0);
    chk("pt in_ready held", 32'(ir[1]), 32'd0);
    #1;
    in_data = 32'h301; out_ready = 1'b1;
    #1;
    chk("pt in_ready comb", 32'(ir[1]), 32'd1);
    @(posedge clk);
    @(negedge clk);
    chk("pt noskid data", od[1], 32'h301);
    chk("pt skid data", od[0], 32'h301);
    chk("pt skid occ", 32'(occ[0]), 32'd1);
    apply(0, '0, '0, 1, 0, 0);

    // Counter saturation, flush keeps it, CLR clears it
    apply(1, 32'h400, 8'h01, 0, 0, 0);
    for (int i = 0; i < 20; i++) apply(0, '0, '0, 0, 0, 0);
    chk("sat skid", 32'(sc[0]), 32'd15);
    chk("sat noskid", 32'(sc[1]), 32'd15);
    apply(0, '0, '0, 0, 1, 0);
    chk("sat after flush", 32'(sc[0]), 32'd15);
    apply(0, '0, '0, 0, 0, 1);
    chk("clr stall_cnt", 32'(sc[0]), 32'd0);
    chk("clr noskid stall_cnt", 32'(sc[1]), 32'd0);
    apply(0, '0, '0, 0, 0, 0);
    chk("clr in_ready", 32'(ir[0]), 32'd1);
    chk("clr out_data", od[0], 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
